wb_dma_ram_arb: RTL
===================

Name: wb_dma_ram_arb

Overview:
Parametrised successor to the single-channel DMA RAM.
- One block RAM with two access paths, both on one clock.
- Port A is a Wishbone classic slave for the CPU.
- Port B is shared by RAW_CHANNELS DMA engines (frequency-meter capture channels) through a round-robin arbiter.
- Adds write-collision protection, an error response for out-of-range addresses, and per-channel read-valid strobes.

Parameters:
NUM_OF_MEM_UNITS_TO_USE, 1, number of `MEMORY_UNIT_SIZE blocks used; MEMORY_CELLS_NUMBER = NUM_OF_MEM_UNITS_TO_USE*`MEMORY_UNIT_SIZE/32
WB_ADDR_WIDTH, $clog2(NUM_OF_MEM_UNITS_TO_USE*`MEMORY_UNIT_SIZE), byte address width; word index = adr[WB_ADDR_WIDTH-1:2]
RAW_CHANNELS, 2, number of RAW requesters (1..8)
INIT_FILE_NAME, "NONE", $readmemh image loaded at elaboration

Ports:
wb_clk  in  1  single clock for all logic
wb_rst  in  1  synchronous active-high reset
wb_adr_i  in  WB_ADDR_WIDTH  WB byte address
wb_dat_i  in  32  WB write data
wb_dat_o  out  32  WB read data, registered
wb_we_i  in  1  WB write enable
wb_sel_i  in  4  WB byte selects
wb_stb_i  in  1  WB strobe
wb_cyc_i  in  1  WB cycle
wb_ack_o  out  1  WB acknowledge
wb_err_o  out  1  WB error (out-of-range word)
raw_req_i  in  RAW_CHANNELS  per-channel request; held until granted
raw_we_i  in  RAW_CHANNELS  per-channel write enable
raw_adr_i  in  RAW_CHANNELS*WB_ADDR_WIDTH  packed byte addresses, channel n at [n*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]
raw_dat_i  in  RAW_CHANNELS*32  packed write data
raw_gnt_o  out  RAW_CHANNELS  one-hot, combinational; request consumed at this edge
raw_vld_o  out  RAW_CHANNELS  one-hot, registered; raw_dat_o/raw_err_o valid
raw_dat_o  out  32  read data of the granted access (old data on writes)
raw_err_o  out  1  the access reported by raw_vld_o was out of range
coll_cnt_o  out  16  collision counter (see Optional Feature)

Behaviour:
Reset (sync, wb_rst=1 at edge):
- wb_ack_o, wb_err_o, raw_vld_o, raw_err_o = 0.
- raw_dat_o, wb_dat_o = 0.
- Round-robin pointer = RAW_CHANNELS-1, so channel 0 has first priority.
- Memory contents are not cleared.
- A WB cycle in flight during reset gets no ack; the master must reissue it.
- raw_gnt_o = 0 while wb_rst=1.

WB port:
- Access when cyc&stb&~ack&~err.
- In range (word index < MEMORY_CELLS_NUMBER): byte-enabled write per wb_sel_i; read-first, so wb_dat_o returns the old word; wb_ack_o one cycle after stb.
- Out of range: no write, wb_err_o one cycle after stb, wb_dat_o unchanged.
- ack/err are single-cycle pulses; back-to-back accesses give ack every second cycle.

RAW arbiter:
- Each cycle, grant the first requesting channel after the pointer (wrap at RAW_CHANNELS-1 -> 0). Pointer updates to the granted channel.
- Granted access: full 32-bit write if raw_we_i; read-first.
- Next cycle: raw_vld_o[n]=1 with raw_dat_o; raw_err_o=1 if out of range, in which case the write is suppressed and raw_dat_o=0.
- Latency: gnt at edge k, vld at edge k+1. Throughput: one access per cycle across all channels.
- A requester with no other contenders is granted every cycle.

Collision rule:
- Condition: a WB in-range write is accepted this cycle, the candidate RAW access is also a write, and the word indices match.
- Result: the RAW grant is withheld (stall), the pointer is unchanged, and the channel retries next cycle. WB always wins.
- Cross-port read of a word being written in the same cycle returns old data.

Optional Feature:
Macro WB_DMA_RAM_COLL_CNT_EN.
- Defined: coll_cnt_o is a 16-bit counter, +1 per collision stall, saturating at 16'hFFFF, cleared only by wb_rst.
- Undefined: coll_cnt_o tied to 16'h0000 and the counter logic is absent. Collision stall behaviour is identical in both cases.

Test Plan:
WB write 0xDEADBEEF sel=4'b1111 to 0x10, then read 0x10 -> ack one cycle after each stb; read returns 0xDEADBEEF; err never set.
WB write 0x000000AA sel=4'b0001 over 0x11223344 at 0x20 -> reread gives 0x112233AA.
WB read at word index MEMORY_CELLS_NUMBER -> wb_err_o pulses one cycle; no ack; memory unchanged.
RAW_CHANNELS=2, both req held 4 cycles, reads of 0x0 (ch0) and 0x4 (ch1) -> gnt sequence 0,1,0,1; vld follows one cycle later with the matching data.
Same cycle: WB write 0x55 and ch0 RAW write 0x66, both to 0x8 -> ch0 gnt delayed one cycle; final word 0x66; coll_cnt_o=1 with macro defined, 0 without.
wb_rst asserted while ch1 req pending and WB stb active -> no ack, no vld after reset; the next grant goes to ch0 first.

Source files
------------

// File: rtl/wb_dma_ram_arb.sv
// wb_dma_ram_arb: one block RAM shared by a CPU port and several DMA engines.
//
// Port A (wb_*) is a Wishbone classic slave for the CPU. Port B (raw_*) is
// shared by RAW_CHANNELS DMA requesters through a round-robin arbiter. Both
// paths are read-first and run on wb_clk. Accesses to word indices at or above
// MEMORY_CELLS_NUMBER return an error response and never write.
//
// Ports:
//   wb_clk, wb_rst      clock, synchronous active-high reset
//   wb_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i   Wishbone request
//   wb_dat_o, wb_ack_o, wb_err_o            Wishbone response (registered)
//   raw_req_i/we_i/adr_i/dat_i              packed per-channel DMA requests
//   raw_gnt_o           one-hot combinational grant (request consumed)
//   raw_vld_o/dat_o/err_o  registered response, one cycle after grant
//   coll_cnt_o          count of DMA stalls caused by WB write collisions
//
// Optional feature: define WB_DMA_RAM_COLL_CNT_EN to build the saturating
// collision counter; otherwise coll_cnt_o is tied to zero.

`ifndef MEMORY_UNIT_SIZE
`define MEMORY_UNIT_SIZE 4096
`endif

module wb_dma_ram_arb #(
  parameter int NUM_OF_MEM_UNITS_TO_USE = 1,
  parameter int WB_ADDR_WIDTH           = $clog2(NUM_OF_MEM_UNITS_TO_USE*`MEMORY_UNIT_SIZE),
  parameter int RAW_CHANNELS            = 2,
  parameter     INIT_FILE_NAME          = "NONE"
) (
  input  logic                                  wb_clk,
  input  logic                                  wb_rst,
  input  logic [WB_ADDR_WIDTH-1:0]              wb_adr_i,
  input  logic [31:0]                           wb_dat_i,
  output logic [31:0]                           wb_dat_o,
  input  logic                                  wb_we_i,
  input  logic [3:0]                            wb_sel_i,
  input  logic                                  wb_stb_i,
  input  logic                                  wb_cyc_i,
  output logic                                  wb_ack_o,
  output logic                                  wb_err_o,
  input  logic [RAW_CHANNELS-1:0]               raw_req_i,
  input  logic [RAW_CHANNELS-1:0]               raw_we_i,
  input  logic [RAW_CHANNELS*WB_ADDR_WIDTH-1:0] raw_adr_i,
  input  logic [RAW_CHANNELS*32-1:0]            raw_dat_i,
  output logic [RAW_CHANNELS-1:0]               raw_gnt_o,
  output logic [RAW_CHANNELS-1:0]               raw_vld_o,
  output logic [31:0]                           raw_dat_o,
  output logic                                  raw_err_o,
  output logic [15:0]                           coll_cnt_o
);

  localparam int unsigned CELLS = NUM_OF_MEM_UNITS_TO_USE*`MEMORY_UNIT_SIZE/32;
  localparam int MW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int PW = (RAW_CHANNELS > 1) ? $clog2(RAW_CHANNELS) : 1;
  localparam int IW = WB_ADDR_WIDTH - 2;

  logic [31:0] mem [CELLS];

  logic                    wb_ack_q, wb_err_q;
  logic [31:0]             wb_dat_q;
  logic [RAW_CHANNELS-1:0] raw_vld_q;
  logic                    raw_err_q;
  logic [31:0]             raw_dat_q;
  logic [PW-1:0]           ptr_q, ptr_d;

  // WB side
  logic          wb_acc, wb_in, wb_wr;
  logic [IW-1:0] wb_idx;

  assign wb_idx = wb_adr_i[WB_ADDR_WIDTH-1:2];
  assign wb_acc = wb_cyc_i & wb_stb_i & ~wb_ack_q & ~wb_err_q & ~wb_rst;
  assign wb_in  = 32'(wb_idx) < CELLS;
  assign wb_wr  = wb_acc & wb_in & wb_we_i;

  // Round-robin candidate: first requester strictly above the pointer, else
  // the first requester at or below it. Two constant-index passes keep the
  // search free of modulo arithmetic.
  logic                     cand_found;
  logic [PW-1:0]            cand_idx;
  logic [RAW_CHANNELS-1:0]  cand_oh;
  logic                     cand_we;
  logic [WB_ADDR_WIDTH-1:0] cand_adr;
  logic [31:0]              cand_dat;
  logic                     unused_bits;

  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_oh    = '0;
    cand_we    = 1'b0;
    cand_adr   = '0;
    cand_dat   = '0;
    for (int unsigned i = 0; i < RAW_CHANNELS; i++) begin
      if (!cand_found && raw_req_i[i] && (i > 32'(ptr_q))) begin
        cand_found = 1'b1;
        cand_idx   = PW'(i);
        cand_oh[i] = 1'b1;
        cand_we    = raw_we_i[i];
        cand_adr   = raw_adr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        cand_dat   = raw_dat_i[i*32 +: 32];
      end
    end
    for (int unsigned i = 0; i < RAW_CHANNELS; i++) begin
      if (!cand_found && raw_req_i[i] && (i <= 32'(ptr_q))) begin
        cand_found = 1'b1;
        cand_idx   = PW'(i);
        cand_oh[i] = 1'b1;
        cand_we    = raw_we_i[i];
        cand_adr   = raw_adr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        cand_dat   = raw_dat_i[i*32 +: 32];
      end
    end
  end

  // Byte-offset bits are don't-care on both ports.
  always_comb begin
    unused_bits = ^wb_adr_i[1:0];
    for (int unsigned i = 0; i < RAW_CHANNELS; i++)
      unused_bits = unused_bits ^ (^raw_adr_i[i*WB_ADDR_WIDTH +: 2]);
  end

  logic [IW-1:0] cand_widx;
  logic          cand_in, coll, raw_grant, raw_wr;

  assign cand_widx = cand_adr[WB_ADDR_WIDTH-1:2];
  assign cand_in   = 32'(cand_widx) < CELLS;
  // WB always wins a same-word write race; the DMA channel simply retries.
  assign coll      = cand_found & wb_wr & cand_we & (cand_widx == wb_idx);
  assign raw_grant = cand_found & ~coll & ~wb_rst;
  assign raw_wr    = raw_grant & cand_we & cand_in;
  assign raw_gnt_o = raw_grant ? cand_oh : '0;
  assign ptr_d     = raw_grant ? cand_idx : ptr_q;

  // Memory array: no reset, writes gated by the access qualifiers above.
  always_ff @(posedge wb_clk) begin
    if (wb_wr) begin
      for (int unsigned b = 0; b < 4; b++)
        if (wb_sel_i[b]) mem[wb_idx[MW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
    end
    if (raw_wr) mem[cand_widx[MW-1:0]] <= cand_dat;
  end

  // Response registers (read-first: they sample the pre-write contents).
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack_q  <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_dat_q  <= '0;
      raw_vld_q <= '0;
      raw_err_q <= 1'b0;
      raw_dat_q <= '0;
      ptr_q     <= PW'(RAW_CHANNELS-1);
    end else begin
      wb_ack_q  <= wb_acc & wb_in;
      wb_err_q  <= wb_acc & ~wb_in;
      if (wb_acc && wb_in) wb_dat_q <= mem[wb_idx[MW-1:0]];
      raw_vld_q <= raw_gnt_o;
      raw_err_q <= raw_grant & ~cand_in;
      if (raw_grant) raw_dat_q <= cand_in ? mem[cand_widx[MW-1:0]] : '0;
      ptr_q     <= ptr_d;
    end
  end

`ifdef WB_DMA_RAM_COLL_CNT_EN
  logic [15:0] coll_cnt_q;
  always_ff @(posedge wb_clk) begin
    if (wb_rst)                            coll_cnt_q <= '0;
    else if (coll && (coll_cnt_q != '1))   coll_cnt_q <= coll_cnt_q + 16'd1;
  end
  assign coll_cnt_o = coll_cnt_q;
`else
  assign coll_cnt_o = '0;
`endif

  assign wb_ack_o  = wb_ack_q;
  assign wb_err_o  = wb_err_q;
  assign wb_dat_o  = wb_dat_q;
  assign raw_vld_o = raw_vld_q;
  assign raw_err_o = raw_err_q;
  assign raw_dat_o = raw_dat_q;

endmodule
